// File: rtl/spi_responder_if.sv
// SPI pin bundle and byte-stream handshake for the SPI mode-0 responder.
// The slave modport is the responder's view; master is the controller/user-logic view.
interface spi_responder_if;
  logic       spi_sck;
  logic       spi_ss;
  logic       spi_sdi;
  logic       spi_sdo;
  logic       spi_sdo_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       tx_underrun;
  logic       frame_active;

  modport slave (
    input  spi_sck, spi_ss, spi_sdi, tx_data, tx_valid,
    output spi_sdo, spi_sdo_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_active
  );

  modport master (
    output spi_sck, spi_ss, spi_sdi, tx_data, tx_valid,
    input  spi_sdo, spi_sdo_oe, tx_ready, rx_data, rx_valid, tx_underrun, frame_active
  );
endinterface

// File: rtl/spi_responder.sv
// SPI mode-0 responder: oversamples sck/ss/sdi in the 16 MHz domain and
// exchanges bytes with user logic over valid/ready streams.
module spi_responder #(
  parameter logic [7:0]  DEFAULT_TX  = 8'hFF,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic             clk_16mhz,
  input logic             reset,
  spi_responder_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_ACTIVE
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] ss_sync_q,  ss_sync_d;
  logic [SYNC_STAGES-1:0] sdi_sync_q, sdi_sync_d;
  logic                   sck_prev_q, sck_prev_d;
  logic                   ss_prev_q,  ss_prev_d;
  logic                   sdi_prev_q, sdi_prev_d;

  // Only the not-yet-driven bits are kept; the current bit lives in sdo_q.
  logic [6:0] tx_shift_q, tx_shift_d;
  logic [6:0] rx_shift_q, rx_shift_d;
  logic [2:0] bit_cnt_q,  bit_cnt_d;
  logic       sdo_q,      sdo_d;
  logic [7:0] hold_q,     hold_d;
  logic       hold_full_q, hold_full_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_underrun_q, tx_underrun_d;
  logic       armed_q,    armed_d;

  logic       sck_s, ss_s;
  logic       sck_rise, sck_fall, ss_fall, ss_rise;
  logic       start_frame, end_frame, act_rise, act_fall;
  logic       load_tx, shift_tx, tx_write;
  logic [7:0] next_byte;
  logic [7:0] rx_byte;

  // ---------------------------------------------------------------------------
  // Synchronisers and edge-detect stage
  // ---------------------------------------------------------------------------
  always_comb begin
    sck_sync_d = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
    ss_sync_d  = {ss_sync_q[SYNC_STAGES-2:0],  bus.spi_ss};
    sdi_sync_d = {sdi_sync_q[SYNC_STAGES-2:0], bus.spi_sdi};
    sck_prev_d = sck_sync_q[SYNC_STAGES-1];
    ss_prev_d  = ss_sync_q[SYNC_STAGES-1];
    sdi_prev_d = sdi_sync_q[SYNC_STAGES-1];
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;
  assign ss_fall  = ~ss_s  &  ss_prev_q;
  assign ss_rise  =  ss_s  & ~ss_prev_q;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ss_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (ss_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    start_frame      = 1'b0;
    end_frame        = 1'b0;
    act_rise         = 1'b0;
    act_fall         = 1'b0;
    bus.spi_sdo_oe   = 1'b0;
    bus.frame_active = 1'b0;
    case (state_q)
      ST_IDLE: begin
        start_frame = ss_fall;
      end
      ST_ACTIVE: begin
        bus.spi_sdo_oe   = 1'b1;
        bus.frame_active = 1'b1;
        end_frame        = ss_rise;
        // Frame end wins over a coincident sck edge; edges wait for sck low first.
        act_rise         = ~ss_rise & armed_q & sck_rise;
        act_fall         = ~ss_rise & armed_q & sck_fall;
      end
      default: ;
    endcase
  end

  assign bus.spi_sdo     = sdo_q;
  assign bus.tx_ready    = ~hold_full_q;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.tx_underrun = tx_underrun_q;

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  assign next_byte = hold_full_q ? hold_q : DEFAULT_TX;
  assign load_tx   = start_frame | (act_fall & (bit_cnt_q == 3'd0));
  assign shift_tx  = act_fall & (bit_cnt_q != 3'd0);
  assign tx_write  = bus.tx_valid & ~hold_full_q;
  assign rx_byte   = {rx_shift_q, sdi_prev_q};

  always_comb begin
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    sdo_d         = sdo_q;
    hold_d        = hold_q;
    hold_full_d   = hold_full_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    tx_underrun_d = 1'b0;
    armed_d       = armed_q;

    if (start_frame) begin
      armed_d = ~sck_s;
    end else if (state_q == ST_ACTIVE && !sck_s) begin
      armed_d = 1'b1;
    end

    if (load_tx) begin
      tx_shift_d    = next_byte[6:0];
      sdo_d         = next_byte[7];
      tx_underrun_d = ~hold_full_q;
    end else if (shift_tx) begin
      tx_shift_d = {tx_shift_q[5:0], 1'b0};
      sdo_d      = tx_shift_q[6];
    end

    if (act_rise) begin
      rx_shift_d = rx_byte[6:0];
      bit_cnt_d  = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        rx_data_d  = rx_byte;
        rx_valid_d = 1'b1;
      end
    end

    if (state_q == ST_IDLE || end_frame) begin
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end

    // A load from an empty register coinciding with a write leaves it full.
    if (tx_write) begin
      hold_d      = bus.tx_data;
      hold_full_d = 1'b1;
    end else if (load_tx) begin
      hold_full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_16mhz or posedge reset) begin
    if (reset) begin
      sck_sync_q    <= '0;
      ss_sync_q     <= '1;
      sdi_sync_q    <= '0;
      sck_prev_q    <= 1'b0;
      ss_prev_q     <= 1'b1;
      sdi_prev_q    <= 1'b0;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      sdo_q         <= 1'b1;
      hold_q        <= '0;
      hold_full_q   <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      armed_q       <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      ss_sync_q     <= ss_sync_d;
      sdi_sync_q    <= sdi_sync_d;
      sck_prev_q    <= sck_prev_d;
      ss_prev_q     <= ss_prev_d;
      sdi_prev_q    <= sdi_prev_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      sdo_q         <= sdo_d;
      hold_q        <= hold_d;
      hold_full_q   <= hold_full_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      tx_underrun_q <= tx_underrun_d;
      armed_q       <= armed_d;
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// Directed self-checking bench for spi_responder: a 1 MHz mode-0 controller
// model drives the pins; user-side bytes are written and logged by the bench.
`timescale 1ns/1ps
module tb_spi_responder;

  logic clk_16mhz = 1'b0;
  logic reset     = 1'b1;

  spi_responder_if bus ();

  spi_responder #(
    .DEFAULT_TX  (8'hFF),
    .SYNC_STAGES (2)
  ) dut (
    .clk_16mhz (clk_16mhz),
    .reset     (reset),
    .bus       (bus)
  );

  always #31.25 clk_16mhz = ~clk_16mhz;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  int unsigned rx_cnt = 0;
  int unsigned un_cnt = 0;
  int unsigned wr_cnt = 0;
  logic [7:0]  rx_log [0:63];

  always @(negedge clk_16mhz) begin
    if (bus.rx_valid) begin
      rx_log[rx_cnt % 64] = bus.rx_data;
      rx_cnt++;
    end
    if (bus.tx_underrun) un_cnt++;
  end

  // Handshake is sampled at the edge the DUT uses; inputs change only at negedge+1.
  always @(posedge clk_16mhz) begin
    if (bus.tx_valid && bus.tx_ready) wr_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk_16mhz);
    #1;
  endtask

  task automatic write_tx(input logic [7:0] b);
    int unsigned n;
    n = 0;
    while (!bus.tx_ready && n < 200) begin
      step(1);
      n++;
    end
    check("tx_ready_wait", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    step(1);
    bus.tx_valid = 1'b0;
  endtask

  // One mode-0 transfer of nbits (MSB first); with last set, ss rises with the final sck fall.
  task automatic spi_xfer(input logic [7:0] mosi, input int nbits, input bit last,
                          output logic [7:0] miso);
    miso = '0;
    for (int k = 0; k < nbits; k++) begin
      bus.spi_sdi = mosi[7-k];
      step(8);
      bus.spi_sck = 1'b1;
      miso[7-k]   = bus.spi_sdo;
      step(8);
      bus.spi_sck = 1'b0;
      if (last && k == nbits - 1) bus.spi_ss = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sdo"},     32'(bus.spi_sdo),      32'd1);
    check({tag, "_oe"},      32'(bus.spi_sdo_oe),   32'd0);
    check({tag, "_ready"},   32'(bus.tx_ready),     32'd1);
    check({tag, "_rxdata"},  32'(bus.rx_data),      32'h0);
    check({tag, "_rxvalid"}, 32'(bus.rx_valid),     32'd0);
    check({tag, "_under"},   32'(bus.tx_underrun),  32'd0);
    check({tag, "_frame"},   32'(bus.frame_active), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]  m0, m1, m2, m3;
    int unsigned rx0, un0, wr0;

    bus.spi_sck  = 1'b0;
    bus.spi_ss   = 1'b1;
    bus.spi_sdi  = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    // Reset state
    step(3);
    check_reset_outputs("rst");
    reset = 1'b0;
    step(3);
    check_reset_outputs("post_rst");

    // Single byte: A5 out, 3C in
    write_tx(8'hA5);
    check("t1_ready_full", 32'(bus.tx_ready), 32'd0);
    rx0 = rx_cnt; un0 = un_cnt;
    bus.spi_ss = 1'b0;
    step(2);
    check("t1_oe_early", 32'(bus.spi_sdo_oe), 32'd0);
    step(1);
    check("t1_oe", 32'(bus.spi_sdo_oe), 32'd1);
    check("t1_frame", 32'(bus.frame_active), 32'd1);
    check("t1_sdo_msb", 32'(bus.spi_sdo), 32'd1);
    check("t1_ready_after_load", 32'(bus.tx_ready), 32'd1);
    spi_xfer(8'h3C, 8, 1'b1, m0);
    step(3);
    check("t1_miso", 32'(m0), 32'hA5);
    check("t1_rx_count", rx_cnt - rx0, 32'd1);
    check("t1_rx_data", 32'(rx_log[rx0 % 64]), 32'h3C);
    check("t1_underrun", un_cnt - un0, 32'd0);
    check("t1_oe_off", 32'(bus.spi_sdo_oe), 32'd0);

    // Three bytes, third one underruns
    write_tx(8'h01);
    rx0 = rx_cnt; un0 = un_cnt;
    bus.spi_ss = 1'b0;
    step(3);
    write_tx(8'h02);
    spi_xfer(8'h10, 8, 1'b0, m0);
    spi_xfer(8'h20, 8, 1'b0, m1);
    spi_xfer(8'h30, 8, 1'b1, m2);
    step(3);
    check("t2_miso0", 32'(m0), 32'h01);
    check("t2_miso1", 32'(m1), 32'h02);
    check("t2_miso2", 32'(m2), 32'hFF);
    check("t2_underrun", un_cnt - un0, 32'd1);
    check("t2_rx_count", rx_cnt - rx0, 32'd3);
    check("t2_rx0", 32'(rx_log[(rx0 + 0) % 64]), 32'h10);
    check("t2_rx1", 32'(rx_log[(rx0 + 1) % 64]), 32'h20);
    check("t2_rx2", 32'(rx_log[(rx0 + 2) % 64]), 32'h30);

    // Aborted frame after 5 bits, then a clean frame
    rx0 = rx_cnt;
    bus.spi_ss = 1'b0;
    step(3);
    spi_xfer(8'hFF, 5, 1'b1, m0);
    step(2);
    check("t3_oe_still_on", 32'(bus.spi_sdo_oe), 32'd1);
    step(1);
    check("t3_oe_off", 32'(bus.spi_sdo_oe), 32'd0);
    check("t3_no_rx", rx_cnt - rx0, 32'd0);
    step(4);
    bus.spi_ss = 1'b0;
    step(3);
    spi_xfer(8'h81, 8, 1'b1, m0);
    step(3);
    check("t3_rx_count", rx_cnt - rx0, 32'd1);
    check("t3_rx", 32'(rx_log[rx0 % 64]), 32'h81);

    // tx_valid held with 55 across four byte loads
    un0 = un_cnt; wr0 = wr_cnt;
    bus.tx_data  = 8'h55;
    bus.tx_valid = 1'b1;
    step(2);
    bus.spi_ss = 1'b0;
    step(3);
    spi_xfer(8'h00, 8, 1'b0, m0);
    spi_xfer(8'h00, 8, 1'b0, m1);
    spi_xfer(8'h00, 8, 1'b0, m2);
    spi_xfer(8'h00, 8, 1'b1, m3);
    step(3);
    bus.tx_valid = 1'b0;
    check("t4_miso0", 32'(m0), 32'h55);
    check("t4_miso1", 32'(m1), 32'h55);
    check("t4_miso2", 32'(m2), 32'h55);
    check("t4_miso3", 32'(m3), 32'h55);
    check("t4_writes", wr_cnt - wr0, 32'd5);
    check("t4_underrun", un_cnt - un0, 32'd0);
    check("t4_hold_full", 32'(bus.tx_ready), 32'd0);

    // sck toggling with ss high is ignored
    rx0 = rx_cnt; un0 = un_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.spi_sdi = i[0];
      bus.spi_sck = 1'b1;
      step(4);
      check("t5_oe_idle", 32'(bus.spi_sdo_oe), 32'd0);
      bus.spi_sck = 1'b0;
      step(4);
    end
    check("t5_no_rx", rx_cnt - rx0, 32'd0);
    bus.spi_ss = 1'b0;
    step(3);
    check("t5_sdo_msb", 32'(bus.spi_sdo), 32'd0);
    spi_xfer(8'hC3, 8, 1'b1, m0);
    step(3);
    check("t5_miso", 32'(m0), 32'h55);
    check("t5_underrun", un_cnt - un0, 32'd0);
    check("t5_rx_count", rx_cnt - rx0, 32'd1);
    check("t5_rx", 32'(rx_log[rx0 % 64]), 32'hC3);

    // Reset mid-byte, then a fresh frame sends DEFAULT_TX
    bus.spi_ss = 1'b0;
    step(3);
    spi_xfer(8'hF0, 4, 1'b0, m0);
    step(2);
    reset = 1'b1;
    step(1);
    check_reset_outputs("t6");
    bus.spi_ss = 1'b1;
    step(3);
    reset = 1'b0;
    step(5);
    rx0 = rx_cnt; un0 = un_cnt;
    bus.spi_ss = 1'b0;
    step(3);
    check("t6_oe", 32'(bus.spi_sdo_oe), 32'd1);
    check("t6_underrun", un_cnt - un0, 32'd1);
    spi_xfer(8'h5A, 8, 1'b1, m0);
    step(3);
    check("t6_miso", 32'(m0), 32'hFF);
    check("t6_rx_count", rx_cnt - rx0, 32'd1);
    check("t6_rx", 32'(rx_log[rx0 % 64]), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_responder.md
Name: spi_responder

Overview:
- SPI mode-0 peripheral (responder) for the board's SPI header pins: sdo, sdi, sck, ss.
- An external controller drives sck and ss. This block shifts in bytes from sdi and shifts out bytes on sdo.
- sck, ss and sdi are oversampled in the 16 MHz system domain.
- The user logic sees byte-wide valid/ready streams. sdo is tri-stated via an output enable whenever ss is high, matching the board's idle-pin convention (undriven pins are high-Z).

Parameters:
- DEFAULT_TX, 8'hFF, byte shifted out when no TX byte is buffered at a byte boundary.
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers (minimum 2).

Ports:
- clk_16mhz  input  1  system clock, 16 MHz.
- reset  input  1  asynchronous, active-high reset.
- spi_sck  input  1  raw SCK from pin.
- spi_ss  input  1  raw slave-select from pin, active-low.
- spi_sdi  input  1  raw controller-to-responder data.
- spi_sdo  output  1  responder-to-controller data.
- spi_sdo_oe  output  1  output enable for the sdo pad; 0 means high-Z.
- tx_data  input  8  next byte to send.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  holding register empty.
- rx_data  output  8  last complete received byte.
- rx_valid  output  1  one-cycle pulse: rx_data updated.
- tx_underrun  output  1  one-cycle pulse: DEFAULT_TX loaded because no byte was buffered.
- frame_active  output  1  synchronised ss asserted.

Behaviour:
- Reset values:
  - spi_sdo=1, spi_sdo_oe=0, tx_ready=1, rx_data=0, rx_valid=0, tx_underrun=0, frame_active=0.
  - Shift registers 0, bit counter 0, holding register empty.
  - Synchronisers reset to sck=0, ss=1, sdi=0.
- Synchronisation and edge detection:
  - sck, ss and sdi each pass through SYNC_STAGES flops, then one edge-detect flop.
  - A pin edge is acted on SYNC_STAGES+1 cycles later.
  - Each SCK high and low phase must be at least 4 clk_16mhz cycles, so SCK is at most 2 MHz. Faster SCK is unsupported and undefined.
- State machine:
  - IDLE: synchronised ss=1; spi_sdo_oe=0; bit counter held at 0.
  - IDLE->ACTIVE on synchronised ss falling edge. In the same cycle:
    - load the TX shift register from the holding register, or from DEFAULT_TX if empty (pulse tx_underrun);
    - drive spi_sdo = bit 7 of that byte;
    - set spi_sdo_oe=1 and frame_active=1.
  - ACTIVE, on each synchronised sck rising edge: shift sdi into the RX shift register MSB-first and increment the bit counter (3-bit, wraps 7->0).
  - ACTIVE, on the 8th rising edge (counter 7->0):
    - rx_data takes the completed byte;
    - rx_valid pulses for exactly one cycle, the cycle after the edge is detected.
  - ACTIVE, on each synchronised sck falling edge:
    - if the counter is 0, a byte boundary has passed: load the next TX byte (holding register or DEFAULT_TX + tx_underrun pulse) and drive its bit 7;
    - otherwise shift the TX register left and drive the next bit.
  - ACTIVE->IDLE on synchronised ss rising edge, at any bit position:
    - partial RX byte discarded, no rx_valid;
    - partial TX byte dropped, holding register untouched;
    - spi_sdo_oe=0 and frame_active=0 the same cycle; counter reset to 0.
- TX holding register:
  - Single entry; tx_ready = !full (registered).
  - tx_valid && tx_ready writes the register.
  - If a load empties the register in the same cycle as a write, the register ends full with the new byte.
  - tx_valid while tx_ready=0 is ignored; the producer must hold it.
- SCK edges while ss is high are ignored. ss asserting while sck is high is a protocol error; no edges are acted on until sck returns low.
- rx_data holds its value until the next complete byte. There is no backpressure on RX, so the consumer must take each byte within 8 SCK periods.
- Asserting reset mid-frame returns to the reset state immediately. After reset is released, the block waits for a fresh ss falling edge.

Test Plan:
- Reset, then ss low with tx byte 8'hA5 preloaded; controller sends 8'h3C at 1 MHz -> spi_sdo_oe rises; controller samples 8'hA5; rx_valid pulses once with rx_data=8'h3C; tx_ready high after load.
- Three-byte frame, TX bytes 8'h01 and 8'h02 written in time, third not written; controller sends 8'h10,8'h20,8'h30 -> sdo bytes 8'h01,8'h02,8'hFF; one tx_underrun pulse at the third load; rx_valid ×3 with 8'h10,8'h20,8'h30.
- ss deasserted after 5 bits of 8'hFF -> no rx_valid; spi_sdo_oe=0 within SYNC_STAGES+1 cycles; next frame receives 8'h81 correctly (counter restarted).
- tx_valid held continuously with 8'h55 during a byte-boundary load -> exactly one byte consumed per load; no byte lost or duplicated over 4 bytes.
- SCK toggling with ss high -> no rx_valid, spi_sdo_oe stays 0, bit counter stays 0.
- reset asserted mid-byte -> all outputs at reset values next cycle; after release, a new frame sends DEFAULT_TX 8'hFF with a tx_underrun pulse.
